// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared widths, funct3 codes, BHT counter states and helpers for branch_resolve
package branch_resolve_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef logic [1:0] bht_ctr_t;

    typedef struct packed {
        logic taken;
        logic mispredict;
        logic illegal;
    } resolve_t;

    // Branch condition from the comparator flags; reserved encodings resolve not taken
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        return (f3 == F3_BEQ) ? eq :
               (f3 == F3_BNE) ? ~eq :
               (f3 == F3_BLT || f3 == F3_BLTU) ? lt :
               (f3 == F3_BGE || f3 == F3_BGEU) ? ~lt : 1'b0;
    endfunction

    // 2-bit saturating counter step
    function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
        return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: array of 2-bit saturating counters, combinational read, synchronous update
module bht_2bit
    import branch_resolve_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_ctr_t ctr [2**IDX_W];

    // Read sees the stored value, so a same-cycle update to this index is not visible yet
    assign rd_ctr = ctr[rd_idx];

    // Counters start weakly not taken and train on each resolved branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= WNT;
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution, registered mispredict redirect/flush, BHT owner.
// Optional feature: define BRANCH_STATS_EN to build the branch and mispredict counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int BHT_IDX_W = 4,
    parameter int REG_WIDTH = branch_resolve_pkg::REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic [2:0]           ex_funct3,
    input  logic [REG_WIDTH-1:0] ex_pc,
    input  logic [REG_WIDTH-1:0] ex_target,
    input  logic                 ex_pred_taken,
    input  logic                 BrEq,
    input  logic                 BrLT,
    output logic                 BrUn,
    input  logic [REG_WIDTH-1:0] if_pc,
    output logic                 if_pred_taken,
    output logic                 redirect_valid,
    output logic [REG_WIDTH-1:0] redirect_pc,
    output logic                 flush,
    output logic                 illegal_branch,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    logic                 is_jump;
    logic                 is_cond;
    logic                 resolve;
    logic                 do_redirect;
    resolve_t             res;
    logic [REG_WIDTH-1:0] next_pc;
    bht_ctr_t             if_ctr;
    logic                 unused_if_pc;

    assign unused_if_pc = ^{if_pc[REG_WIDTH-1:BHT_IDX_W+2], if_pc[1:0]};

    // Unsigned compare only for bltu/bgeu
    assign BrUn = ex_funct3[2] & ex_funct3[1];

    // Resolve the EX instruction; the instruction seen during a flush cycle is wrong-path
    always_comb begin
        is_jump        = ex_is_jal | ex_is_jalr;
        is_cond        = ex_is_branch & ~is_jump;
        resolve        = ex_valid & ~stall & ~flush & (is_jump | ex_is_branch);
        res.illegal    = is_cond & (ex_funct3[2:1] == 2'b01);
        res.taken      = is_jump | (is_cond & branch_taken(ex_funct3, BrEq, BrLT));
        res.mispredict = is_jump | (res.taken != ex_pred_taken);
        do_redirect    = resolve & res.mispredict;
        next_pc        = res.taken ? ex_target : ex_pc + REG_WIDTH'(4);
    end

    // Redirect/flush/illegal pulses; held while stalled so fetch cannot miss them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            illegal_branch <= 1'b0;
            redirect_pc    <= '0;
        end else if (!stall) begin
            redirect_valid <= do_redirect;
            flush          <= do_redirect;
            illegal_branch <= resolve & res.illegal;
            if (do_redirect) redirect_pc <= next_pc;
        end
    end

    bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[BHT_IDX_W+1:2]),
        .rd_ctr   (if_ctr),
        .wr_en    (resolve & is_cond),
        .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
        .wr_taken (res.taken)
    );

    assign if_pred_taken = if_ctr[1];

`ifdef BRANCH_STATS_EN
    // Event counters; resolution is already gated by stall so they freeze with the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve & is_cond) stat_branches <= stat_branches + 32'd1;
            if (do_redirect) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: table-driven, directed and randomized checks of branch_resolve against a behavioural model
module tb_branch_resolve;

    logic        clk = 0, rst_n = 0, stall = 0, ex_valid = 0;
    logic        ex_is_branch = 0, ex_is_jal = 0, ex_is_jalr = 0, ex_pred_taken = 0;
    logic        BrEq = 0, BrLT = 0;
    logic [2:0]  ex_funct3 = 0;
    logic [31:0] ex_pc = 0, ex_target = 0, if_pc = 0;
    logic        BrUn, if_pred_taken, redirect_valid, flush, illegal_branch;
    logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

    branch_resolve dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .illegal_branch(illegal_branch),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // Reference model state: counters as plain integers 0..3
    int          m_bht [16];
    bit          m_rv, m_flush, m_ill;
    logic [31:0] m_rpc;
    int unsigned m_sb, m_sm;

    typedef struct packed {
        logic [2:0]  f3;
        bit          br, jl, jr;
        logic [31:0] pc, tgt;
        bit          pr, eq, lt;
        bit          rv;
        logic [31:0] rpc;
        bit          ill;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return v * 0;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_rv = 0; m_flush = 0; m_ill = 0; m_rpc = 0; m_sb = 0; m_sm = 0;
    endtask

    task automatic set(input bit v, input bit br, input bit jl, input bit jr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] tgt, input bit pr, input bit eq, input bit lt);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jl; ex_is_jalr = jr; ex_funct3 = f3;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pr; BrEq = eq; BrLT = lt;
    endtask

    task automatic check_regs();
        check("redirect_valid", redirect_valid, m_rv);
        check("flush", flush, m_flush);
        check("illegal_branch", illegal_branch, m_ill);
        check("redirect_pc", redirect_pc, m_rpc);
        check("stat_branches", stat_branches, stat_exp(m_sb));
        check("stat_mispredicts", stat_mispredicts, stat_exp(m_sm));
    endtask

    // One clock: inputs are already applied at the falling edge; ends on the next falling edge
    task automatic cycle();
        bit jump, res, cond, tk, ill, mis;
        int idx;
        #1;
        check("BrUn", BrUn, (ex_funct3 == 3'd6 || ex_funct3 == 3'd7));
        check("if_pred_taken", if_pred_taken, m_bht[if_pc[5:2]] >= 2);
        jump = ex_is_jal || ex_is_jalr;
        cond = ex_is_branch && !jump;
        res  = ex_valid && !stall && !m_flush && (jump || ex_is_branch);
        ill  = 0;
        case (ex_funct3)
            3'd0: tk = BrEq;
            3'd1: tk = !BrEq;
            3'd4, 3'd6: tk = BrLT;
            3'd5, 3'd7: tk = !BrLT;
            default: begin tk = 0; ill = 1; end
        endcase
        if (jump) tk = 1;
        mis = jump || (tk != ex_pred_taken);
        idx = ex_pc[5:2];
        @(posedge clk);
        #1;
        if (!stall) begin
            m_rv = res && mis;
            m_flush = res && mis;
            m_ill = res && cond && ill;
            if (res && mis) m_rpc = tk ? ex_target : ex_pc + 32'd4;
            if (res && cond) begin
                m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3) : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
                m_sb++;
            end
            if (res && mis) m_sm++;
        end
        check_regs();
        @(negedge clk);
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        cycle();
    endtask

    task automatic do_reset();
        set(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        stall = 0;
        rst_n = 0;
        #2;
        m_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        tbl[0]  = '{3'b000, 1, 0, 0, 32'h100, 32'h180, 0, 1, 0, 1, 32'h180, 0};
        tbl[1]  = '{3'b110, 1, 0, 0, 32'h104, 32'h200, 1, 0, 1, 0, 32'h0, 0};
        tbl[2]  = '{3'b001, 1, 0, 0, 32'h108, 32'h300, 0, 1, 0, 0, 32'h0, 0};
        tbl[3]  = '{3'b101, 1, 0, 0, 32'h10c, 32'h400, 0, 0, 0, 1, 32'h400, 0};
        tbl[4]  = '{3'b000, 1, 0, 0, 32'hFFFF_FFFC, 32'h500, 1, 0, 0, 1, 32'h0, 0};
        tbl[5]  = '{3'b010, 1, 0, 0, 32'h110, 32'h600, 0, 1, 1, 0, 32'h0, 1};
        tbl[6]  = '{3'b011, 1, 0, 0, 32'h114, 32'h700, 1, 1, 1, 1, 32'h118, 1};
        tbl[7]  = '{3'b000, 0, 1, 0, 32'h200, 32'h3000, 0, 0, 0, 1, 32'h3000, 0};
        tbl[8]  = '{3'b000, 0, 0, 1, 32'h204, 32'h3000, 1, 0, 0, 1, 32'h3000, 0};
        tbl[9]  = '{3'b111, 1, 0, 0, 32'h120, 32'h800, 1, 0, 1, 1, 32'h124, 0};
        tbl[10] = '{3'b100, 1, 0, 0, 32'h124, 32'h900, 0, 0, 1, 1, 32'h900, 0};

        // Reset state
        m_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("reset_redirect_valid", redirect_valid, 0);
        check("reset_flush", flush, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            check("reset_if_pred", if_pred_taken, 0);
        end
        if_pc = 0;
        rst_n = 1;
        @(negedge clk);

        // Table vectors, each followed by a flush/idle cycle
        for (int i = 0; i < 11; i++) begin
            set(1, tbl[i].br, tbl[i].jl, tbl[i].jr, tbl[i].f3, tbl[i].pc, tbl[i].tgt, tbl[i].pr, tbl[i].eq, tbl[i].lt);
            cycle();
            check("tbl_redirect_valid", redirect_valid, tbl[i].rv);
            check("tbl_flush", flush, tbl[i].rv);
            check("tbl_illegal", illegal_branch, tbl[i].ill);
            if (tbl[i].rv) check("tbl_redirect_pc", redirect_pc, tbl[i].rpc);
            idle();
            check("tbl_pulse_end", redirect_valid, 0);
        end

        // Counter training and saturation at pc 0x40
        do_reset();
        if_pc = 32'h40;
        set(1, 1, 0, 0, 3'b100, 32'h40, 32'h80, 0, 0, 1);
        cycle();
        check("train_first_update", if_pred_taken, 1);
        idle();
        set(1, 1, 0, 0, 3'b100, 32'h40, 32'h80, 1, 0, 1);
        cycle();
        check("train_correct_no_redirect", redirect_valid, 0);
        cycle();
        set(1, 1, 0, 0, 3'b100, 32'h40, 32'h80, 1, 0, 0);
        cycle();
        check("train_sat_then_dec", if_pred_taken, 1);
        idle();
        set(1, 1, 0, 0, 3'b100, 32'h40, 32'h80, 1, 0, 0);
        cycle();
        check("train_back_to_wnt", if_pred_taken, 0);
        idle();

        // Correct not-taken prediction drives 01 -> 00
        if_pc = 32'h100;
        set(1, 1, 0, 0, 3'b001, 32'h100, 32'h180, 0, 1, 0);
        cycle();
        check("bne_correct_no_redirect", redirect_valid, 0);
        set(1, 1, 0, 0, 3'b000, 32'h100, 32'h180, 0, 1, 0);
        cycle();
        check("bht_dec_then_inc", if_pred_taken, 0);
        idle();

        // Jump followed by a wrong-path mispredicting branch in the flush cycle
        if_pc = 32'h44;
        set(1, 0, 0, 1, 3'b000, 32'h200, 32'h3000, 0, 0, 0);
        cycle();
        check("jalr_redirect_pc", redirect_pc, 32'h3000);
        set(1, 1, 0, 0, 3'b100, 32'h44, 32'h900, 0, 0, 1);
        cycle();
        check("squash_no_redirect", redirect_valid, 0);
        check("squash_no_bht_update", if_pred_taken, 0);
        idle();

        // Redirect held across a stall
        set(1, 1, 0, 0, 3'b000, 32'h300, 32'h380, 0, 1, 0);
        cycle();
        stall = 1;
        set(1, 1, 0, 0, 3'b000, 32'h304, 32'h500, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_hold_redirect", redirect_valid, 1);
            check("stall_hold_pc", redirect_pc, 32'h380);
        end
        stall = 0;
        idle();
        check("stall_release_clears", redirect_valid, 0);

        // Statistics: 5 branches, 2 mispredicts
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set(1, 1, 0, 0, 3'b000, 32'(32'h400 + i * 4), 32'h800, (i < 3), 1, 0);
            cycle();
            idle();
        end
        check("stat_branches_5", stat_branches, stat_exp(5));
        check("stat_mispredicts_2", stat_mispredicts, stat_exp(2));

        // Asynchronous reset while a redirect is pending
        set(1, 0, 1, 0, 3'b000, 32'h600, 32'h4000, 0, 0, 0);
        cycle();
        check("pre_reset_redirect", redirect_valid, 1);
        rst_n = 0;
        #1;
        check("async_reset_redirect_valid", redirect_valid, 0);
        check("async_reset_flush", flush, 0);
        check("async_reset_redirect_pc", redirect_pc, 0);
        check("async_reset_stat_m", stat_mispredicts, 0);
        m_reset();
        set(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int cls;
            cls = $urandom_range(0, 7);
            stall = ($urandom_range(0, 4) == 0);
            if_pc = {$urandom_range(0, 63), 2'b00};
            set($urandom_range(0, 4) != 0, cls >= 2 && cls <= 6, cls == 0, cls == 1,
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'({$urandom_range(0, 63), 2'b00}),
                $urandom & 32'hFFFF_FFFE, 1'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end
        stall = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
